synapse_current_gen: RTL and testbench

//   Upstream stage of the spiking node: turns N_IN incoming spike lines into the unsigned
//   W-bit input current that drives node_async.current. Each input has a programmable

---
 rtl/synapse_pkg.sv | 34 +++
 rtl/synapse_weight_rf.sv | 45 ++++
 rtl/synapse_current_gen.sv | 131 +++++++++++++
 tb/tb_synapse_current_gen.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/synapse_pkg.sv
// ============================================================================
// Module  : synapse_pkg
// Brief   : Shared defaults, weight-port FSM encoding and saturating clamp.
// Revision: 1.0
// ============================================================================
`default_nettype none

package synapse_pkg;

    localparam int c_N_IN_DEF        = 4;
    localparam int c_W_DEF           = 8;
    localparam int c_WEIGHT_W_DEF    = 8;
    localparam int c_DECAY_SHIFT_DEF = 2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } wt_state_t;

    // Saturate a signed value into the unsigned range [0, 2^w-1]; w must be < 31.
    function automatic logic [31:0] clamp_u(input logic signed [31:0] v, input int w);
        int limit;
        limit = (1 << w) - 1;
        if (v < 0)
            return 32'd0;
        else if (v > limit)
            return limit;
        else
            return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/synapse_weight_rf.sv
// ============================================================================
// Module  : synapse_weight_rf
// Brief   : N_IN x WEIGHT_W weight register file, one write port, flat read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module synapse_weight_rf
    import synapse_pkg::*;
#(
    parameter int N_IN     = c_N_IN_DEF,
    parameter int WEIGHT_W = c_WEIGHT_W_DEF,
    parameter int ADDR_W   = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_we,
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic [WEIGHT_W-1:0]        i_data,
    output logic [N_IN*WEIGHT_W-1:0]   o_weights
);

    logic [WEIGHT_W-1:0] r_w [N_IN];

    // Out-of-range addresses match no entry, so such writes are silently dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_IN; i++)
                r_w[i] <= '0;
        end else if (i_we) begin
            for (int i = 0; i < N_IN; i++)
                if (int'(i_addr) == i)
                    r_w[i] <= i_data;
        end
    end

    generate
        for (genvar g = 0; g < N_IN; g++) begin : g_flat
            assign o_weights[g*WEIGHT_W +: WEIGHT_W] = r_w[g];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/synapse_current_gen.sv
// ============================================================================
// Module  : synapse_current_gen
// Brief   : Leaky, saturating accumulator of weighted spikes with a weight port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module synapse_current_gen
    import synapse_pkg::*;
#(
    parameter int N_IN        = c_N_IN_DEF,
    parameter int W           = c_W_DEF,
    parameter int WEIGHT_W    = c_WEIGHT_W_DEF,
    parameter int DECAY_SHIFT = c_DECAY_SHIFT_DEF,
    parameter int ADDR_W      = (N_IN > 1) ? $clog2(N_IN) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_en,
    input  logic                 i_clr,
    input  logic [N_IN-1:0]      i_spike_in,
    input  logic                 i_wt_valid,
    output logic                 o_wt_ready,
    input  logic [ADDR_W-1:0]    i_wt_addr,
    input  logic [WEIGHT_W-1:0]  i_wt_data,
    output logic [W-1:0]         o_current_out,
    output logic                 o_sat
);

    localparam int c_SUM_W = WEIGHT_W + ADDR_W + 1;
    localparam int c_NXT_W = ((W > c_SUM_W) ? W : c_SUM_W) + 2;

    wt_state_t r_state;
    wt_state_t w_state_nxt;
    logic      w_accept;
    logic      w_ready;

    logic [N_IN*WEIGHT_W-1:0]   w_weights;
    logic signed [c_SUM_W-1:0]  w_sum;
    logic [W-1:0]               w_leak;
    logic signed [c_NXT_W-1:0]  w_nxt;
    logic [W-1:0]               w_clamp;
    logic                       w_ovf;

    logic [W-1:0] r_acc;
    logic         r_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ready  = 1'b1;
                w_accept = i_wt_valid;
                if (i_wt_valid)
                    w_state_nxt = ST_COMMIT;
            end
            ST_COMMIT: w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // The write lands on the accept edge, so the integrator sees the old weight there.
    synapse_weight_rf #(
        .N_IN     (N_IN),
        .WEIGHT_W (WEIGHT_W),
        .ADDR_W   (ADDR_W)
    ) u_rf (
        .clk       (clk),
        .rst       (rst),
        .i_we      (w_accept),
        .i_addr    (i_wt_addr),
        .i_data    (i_wt_data),
        .o_weights (w_weights)
    );

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N_IN; i++)
            if (i_spike_in[i])
                w_sum = w_sum + c_SUM_W'(signed'(w_weights[i*WEIGHT_W +: WEIGHT_W]));
    end

    // Minimum leak of 1 guarantees a nonzero accumulator always drains to zero.
    generate
        if (DECAY_SHIFT > 0) begin : g_leak
            logic [W-1:0] w_leak_raw;
            assign w_leak_raw = r_acc >> DECAY_SHIFT;
            assign w_leak = ((r_acc != '0) && (w_leak_raw == '0)) ? W'(1) : w_leak_raw;
        end else begin : g_no_leak
            assign w_leak = '0;
        end
    endgenerate

    assign w_nxt = $signed({{(c_NXT_W-W){1'b0}}, r_acc})
                 - $signed({{(c_NXT_W-W){1'b0}}, w_leak})
                 + $signed({{(c_NXT_W-c_SUM_W){w_sum[c_SUM_W-1]}}, w_sum});

    assign w_ovf   = (w_nxt < 0) || (w_nxt > $signed({{(c_NXT_W-W){1'b0}}, {W{1'b1}}}));
    assign w_clamp = W'(clamp_u({{(32-c_NXT_W){w_nxt[c_NXT_W-1]}}, w_nxt}, W));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_clr) begin
            r_acc <= '0;
            r_sat <= 1'b0;
        end else if (i_en) begin
            r_acc <= w_clamp;
            r_sat <= w_ovf;
        end else begin
            r_sat <= 1'b0;
        end
    end

    assign o_wt_ready    = w_ready;
    assign o_current_out = r_acc;
    assign o_sat         = r_sat;

endmodule

`default_nettype wire

// File: tb/tb_synapse_current_gen.sv
// ============================================================================
// Module  : tb_synapse_current_gen
// Brief   : Directed self-checking bench for synapse_current_gen (N_IN=3).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_synapse_current_gen;

    localparam int c_N_IN   = 3;
    localparam int c_W      = 8;
    localparam int c_WW     = 8;
    localparam int c_ADDR_W = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_en = 1'b0;
    logic              i_clr = 1'b0;
    logic [c_N_IN-1:0] i_spike_in = '0;
    logic              i_wt_valid = 1'b0;
    logic              o_wt_ready;
    logic [c_ADDR_W-1:0] i_wt_addr = '0;
    logic [c_WW-1:0]   i_wt_data = '0;
    logic [c_W-1:0]    o_current_out;
    logic              o_sat;

    int n_checks = 0;
    int n_fail   = 0;

    synapse_current_gen #(
        .N_IN        (c_N_IN),
        .W           (c_W),
        .WEIGHT_W    (c_WW),
        .DECAY_SHIFT (2)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .i_en          (i_en),
        .i_clr         (i_clr),
        .i_spike_in    (i_spike_in),
        .i_wt_valid    (i_wt_valid),
        .o_wt_ready    (o_wt_ready),
        .i_wt_addr     (i_wt_addr),
        .i_wt_data     (i_wt_data),
        .o_current_out (o_current_out),
        .o_sat         (o_sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_w(input logic [c_ADDR_W-1:0] addr, input logic [c_WW-1:0] data);
        int n;
        n = 0;
        while (!o_wt_ready && n < 10) begin
            tick();
            n++;
        end
        chk("wt_ready_wait", 32'(o_wt_ready), 32'd1);
        i_wt_valid = 1'b1;
        i_wt_addr  = addr;
        i_wt_data  = data;
        tick();
        i_wt_valid = 1'b0;
        tick();
    endtask

    int exp_decay [15] = '{40, 30, 23, 18, 14, 11, 9, 7, 6, 5, 4, 3, 2, 1, 0};
    int accepts;

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_cur",   32'(o_current_out), 32'd0);
        chk("rst_sat",   32'(o_sat),         32'd0);
        chk("rst_ready", 32'(o_wt_ready),    32'd1);
        rst = 1'b0;
        tick();

        // Mid-run async reset with acc=0x80 and a COMMIT in flight
        write_w(2'd0, 8'd100);
        write_w(2'd1, 8'd28);
        i_en = 1'b1;
        i_spike_in = 3'b011;
        tick();
        chk("pre_rst_acc", 32'(o_current_out), 32'd128);
        i_en = 1'b0;
        i_spike_in = '0;
        i_wt_valid = 1'b1;
        i_wt_addr = 2'd2;
        i_wt_data = 8'd5;
        tick();
        chk("commit_ready", 32'(o_wt_ready), 32'd0);
        #1 rst = 1'b1;
        i_wt_valid = 1'b0;
        #1;
        chk("async_cur",   32'(o_current_out), 32'd0);
        chk("async_sat",   32'(o_sat),         32'd0);
        chk("async_ready", 32'(o_wt_ready),    32'd1);
        #1 rst = 1'b0;
        i_en = 1'b1;
        i_spike_in = 3'b111;
        tick();
        chk("post_rst_cur", 32'(o_current_out), 32'd0);

        // Single spike decay with leak >= 1
        i_en = 1'b0;
        i_spike_in = '0;
        write_w(2'd0, 8'd40);
        write_w(2'd1, 8'hF6);
        i_en = 1'b1;
        i_spike_in = 3'b001;
        tick();
        chk("decay_0", 32'(o_current_out), 32'(exp_decay[0]));
        i_spike_in = '0;
        for (int i = 1; i < 15; i++) begin
            tick();
            chk($sformatf("decay_%0d", i), 32'(o_current_out), 32'(exp_decay[i]));
        end
        tick();
        chk("decay_hold", 32'(o_current_out), 32'd0);

        // Saturation high then low
        i_en = 1'b0;
        write_w(2'd0, 8'd127);
        i_en = 1'b1;
        i_spike_in = 3'b001;
        tick(); chk("up1_cur", 32'(o_current_out), 32'd127); chk("up1_sat", 32'(o_sat), 32'd0);
        tick(); chk("up2_cur", 32'(o_current_out), 32'd223); chk("up2_sat", 32'(o_sat), 32'd0);
        tick(); chk("up3_cur", 32'(o_current_out), 32'd255); chk("up3_sat", 32'(o_sat), 32'd1);
        tick(); chk("up4_cur", 32'(o_current_out), 32'd255); chk("up4_sat", 32'(o_sat), 32'd1);
        i_en = 1'b0;
        i_spike_in = '0;
        tick(); chk("hi_hold", 32'(o_current_out), 32'd255); chk("hi_sat0", 32'(o_sat), 32'd0);
        write_w(2'd0, 8'h80);
        i_en = 1'b1;
        i_spike_in = 3'b001;
        tick(); chk("dn1_cur", 32'(o_current_out), 32'd64); chk("dn1_sat", 32'(o_sat), 32'd0);
        tick(); chk("dn2_cur", 32'(o_current_out), 32'd0);  chk("dn2_sat", 32'(o_sat), 32'd1);
        tick(); chk("dn3_cur", 32'(o_current_out), 32'd0);  chk("dn3_sat", 32'(o_sat), 32'd1);
        i_en = 1'b0;
        i_spike_in = '0;
        tick(); chk("lo_sat0", 32'(o_sat), 32'd0);

        // Held valid: two accepts in four cycles
        accepts = 0;
        i_wt_valid = 1'b1;
        i_wt_addr = 2'd2;
        i_wt_data = 8'd0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("hold_ready_%0d", i), 32'(o_wt_ready), 32'((i % 2) == 0));
            if (o_wt_ready) accepts++;
            tick();
        end
        i_wt_valid = 1'b0;
        chk("hold_accepts", 32'(accepts), 32'd2);

        // Write on same edge as spike uses old weight
        i_en = 1'b1;
        i_spike_in = 3'b100;
        i_wt_valid = 1'b1;
        i_wt_addr = 2'd2;
        i_wt_data = 8'd50;
        tick();
        i_wt_valid = 1'b0;
        chk("same_edge_old", 32'(o_current_out), 32'd0);
        tick();
        chk("same_edge_new", 32'(o_current_out), 32'd50);

        // Out-of-range address discarded
        i_en = 1'b0;
        i_spike_in = '0;
        write_w(2'd0, 8'd1);
        write_w(2'd1, 8'd2);
        i_clr = 1'b1;
        tick();
        i_clr = 1'b0;
        chk("clr_only", 32'(o_current_out), 32'd0);
        write_w(2'd3, 8'h7F);
        i_en = 1'b1;
        i_spike_in = 3'b111;
        tick();
        chk("oor_cur", 32'(o_current_out), 32'd53);
        chk("oor_sat", 32'(o_sat), 32'd0);

        // clr beats en; en=0 holds
        i_clr = 1'b1;
        tick();
        chk("clr_en_cur", 32'(o_current_out), 32'd0);
        chk("clr_en_sat", 32'(o_sat), 32'd0);
        i_clr = 1'b0;
        tick();
        chk("after_clr", 32'(o_current_out), 32'd53);
        i_en = 1'b0;
        tick();
        chk("en0_hold", 32'(o_current_out), 32'd53);
        chk("en0_sat",  32'(o_sat), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
